sad_row_accumulator: RTL and testbench
======================================

SAD_ROW_ACCUMULATOR -- requirements
Module: sad_row_accumulator

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning rows accumulated per candidate block (2..255).
REQ-002 SHALL have parameter NUM_CAND, default 16, meaning candidate blocks per search (2..16).
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a new search.
REQ-007 in_valid  input  1  a row's redundant pair is present.
REQ-008 in_ready  output  1  block accepts a row this cycle.
REQ-009 sum_vec  input  12  sum row from the 8:2 compressor tree.
REQ-010 carry_vec  input  12  carry row, already weight-aligned with sum_vec.
REQ-011 out_valid  output  1  candidate SAD is valid and held.
REQ-012 out_ready  input  1  consumer takes the candidate SAD.
REQ-013 sad  output  16  SAD of the current candidate block.
REQ-014 cand_idx  output  4  index of the candidate presented on sad.
REQ-015 best_sad  output  16  minimum SAD seen in this search.
REQ-016 best_idx  output  4  index of best_sad.
REQ-017 search_done  output  1  all NUM_CAND candidates consumed.

Function
REQ-018 SHALL implement the states IDLE, RUN, OUT and DONE.
REQ-019 in_ready SHALL be 1 only in RUN; a row is accepted on a cycle where in_valid and in_ready are both 1.
REQ-020 Row value SHALL be the 13-bit zero-extended sum_vec+carry_vec, added into a 16-bit accumulator that wraps modulo 2^16.
REQ-021 A row counter SHALL count accepted rows; on acceptance of row ROWS-1 (0-based), sad <= acc+row, acc and the row counter SHALL clear, and the state SHALL go to OUT.
REQ-022 The latency from the last-row handshake to out_valid=1 SHALL be 1 cycle.
REQ-023 In OUT, out_valid=1, and sad and cand_idx SHALL stay stable until out_ready=1.
REQ-024 On the OUT handshake, if cand_idx==0 or sad<best_sad, then best_sad<=sad and best_idx<=cand_idx.
REQ-025 On a tie (sad==best_sad), the earlier index SHALL be kept.
REQ-026 On the OUT handshake, if cand_idx==NUM_CAND-1, the state SHALL go to DONE; otherwise cand_idx SHALL increment and the state SHALL go to RUN.
REQ-027 In DONE, search_done=1; best_sad and best_idx SHALL be held; in_ready=0.
REQ-028 start SHALL have priority over all events in any state: it clears acc, the row counter, cand_idx, sad and search_done, sets best_sad=16'hFFFF and best_idx=0, and enters RUN next cycle.
REQ-029 A row presented in the same cycle as start SHALL be ignored.
REQ-030 start during a partially accumulated block or a pending OUT SHALL discard that block with no out_valid for it.
REQ-031 In IDLE, in_ready=0 and out_valid=0; only start leaves IDLE.
REQ-032 out_valid SHALL never be 1 in the same cycle as in_ready.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE and set sad=0, cand_idx=0, best_sad=16'hFFFF, best_idx=0, out_valid=0, in_ready=0, search_done=0.
REQ-034 Reset asserted mid-block or mid-search SHALL discard all partial results; no output SHALL reflect pre-reset data after rst deasserts.
REQ-035 After deassertion, the block SHALL remain in IDLE until start.

Verification
REQ-036 Basic block: ROWS=8; start; 8 rows of sum_vec=100, carry_vec=20 with in_valid continuously 1 -> out_valid=1 one cycle after the 8th handshake, sad=960, cand_idx=0.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles -> sad stays 960, in_ready=0 throughout; out_ready=1 -> next state RUN, cand_idx=1.
REQ-038 Minimum tracking: NUM_CAND=4 with candidate SADs 500, 300, 300, 700 -> best_sad=300, best_idx=1, search_done=1 after the 4th out handshake.
REQ-039 Bubbles: in_valid toggling 1,0,1,... over 8 rows of 2040+0 -> sad=16320, counted only on handshakes.
REQ-040 Abort: start after 3 rows of block 2 -> no out_valid for that block, cand_idx=0, best_sad=16'hFFFF; the next 8 rows produce a fresh candidate 0.
REQ-041 Async reset: rst pulse while out_valid=1 -> out_valid=0 immediately without a clock edge; all outputs at reset values; in_ready=0 until start.

Source files
------------

// File: rtl/sad_row_accumulator.sv
// rtl/sad_row_accumulator.sv - accumulates redundant-form row SADs per candidate block and tracks the search minimum
module sad_row_accumulator #(
   parameter int ROWS     = 8,
   parameter int NUM_CAND = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] sum_vec,
   input  logic [11:0] carry_vec,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] sad,
   output logic [3:0]  cand_idx,
   output logic [15:0] best_sad,
   output logic [3:0]  best_idx,
   output logic        search_done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [7:0] LAST_ROW  = 8'(ROWS - 1);
   localparam logic [3:0] LAST_CAND = 4'(NUM_CAND - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [7:0]  row_cnt_q, row_cnt_d;
   logic [15:0] sad_q, sad_d;
   logic [3:0]  cand_q, cand_d;
   logic [15:0] best_sad_q, best_sad_d;
   logic [3:0]  best_idx_q, best_idx_d;

   logic [12:0] row_val;
   logic [15:0] acc_sum;

   // Resolve the redundant pair once; the 13th bit keeps the carry-out of the add.
   assign row_val = {1'b0, sum_vec} + {1'b0, carry_vec};
   assign acc_sum = acc_q + {3'b000, row_val};

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      row_cnt_d  = row_cnt_q;
      sad_d      = sad_q;
      cand_d     = cand_q;
      best_sad_d = best_sad_q;
      best_idx_d = best_idx_q;
      if (start) begin
         state_d    = RUN;
         acc_d      = 16'd0;
         row_cnt_d  = 8'd0;
         sad_d      = 16'd0;
         cand_d     = 4'd0;
         best_sad_d = 16'hFFFF;
         best_idx_d = 4'd0;
      end else begin
         case (state_q)
            RUN: begin
               if (in_valid) begin
                  if (row_cnt_q == LAST_ROW) begin
                     sad_d     = acc_sum;
                     acc_d     = 16'd0;
                     row_cnt_d = 8'd0;
                     state_d   = OUT;
                  end else begin
                     acc_d     = acc_sum;
                     row_cnt_d = row_cnt_q + 8'd1;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  // Strict less-than keeps the earlier index on a tie.
                  if (cand_q == 4'd0 || sad_q < best_sad_q) begin
                     best_sad_d = sad_q;
                     best_idx_d = cand_q;
                  end
                  if (cand_q == LAST_CAND) begin
                     state_d = DONE;
                  end else begin
                     cand_d  = cand_q + 4'd1;
                     state_d = RUN;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= 16'd0;
         row_cnt_q  <= 8'd0;
         sad_q      <= 16'd0;
         cand_q     <= 4'd0;
         best_sad_q <= 16'hFFFF;
         best_idx_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         row_cnt_q  <= row_cnt_d;
         sad_q      <= sad_d;
         cand_q     <= cand_d;
         best_sad_q <= best_sad_d;
         best_idx_q <= best_idx_d;
      end
   end

   assign in_ready    = (state_q == RUN);
   assign out_valid   = (state_q == OUT);
   assign search_done = (state_q == DONE);
   assign sad         = sad_q;
   assign cand_idx    = cand_q;
   assign best_sad    = best_sad_q;
   assign best_idx    = best_idx_q;

endmodule

// File: tb/tb_sad_row_accumulator.sv
// tb/tb_sad_row_accumulator.sv - randomized self-checking bench for sad_row_accumulator
module tb_sad_row_accumulator;

   localparam int ROWS = 8;
   localparam int NC   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] sum_vec;
   logic [11:0] carry_vec;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sad;
   logic [3:0]  cand_idx;
   logic [15:0] best_sad;
   logic [3:0]  best_idx;
   logic        search_done;

   sad_row_accumulator #(.ROWS(ROWS), .NUM_CAND(NC)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .sum_vec(sum_vec), .carry_vec(carry_vec), .out_valid(out_valid), .out_ready(out_ready),
      .sad(sad), .cand_idx(cand_idx), .best_sad(best_sad), .best_idx(best_idx),
      .search_done(search_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [11:0] s_arr[ROWS];
   logic [11:0] c_arr[ROWS];
   int          sads[$];
   int          cur_cand;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: a candidate's SAD is the plain sum of its row values, mod 2^16.
   function automatic int block_sad();
      int t = 0;
      for (int i = 0; i < ROWS; i++) t += int'(s_arr[i]) + int'(c_arr[i]);
      return t % 65536;
   endfunction

   // Reference best: smallest consumed SAD, earliest index among equals.
   task automatic model_best(output int b, output int idx);
      b   = 65535;
      idx = 0;
      if (sads.size() > 0) begin
         b = sads[0];
         foreach (sads[k]) if (sads[k] < b) b = sads[k];
         for (int k = sads.size() - 1; k >= 0; k--) if (sads[k] == b) idx = k;
      end
   endtask

   task automatic set_const(input int s, input int c);
      for (int i = 0; i < ROWS; i++) begin
         s_arr[i] = 12'(s);
         c_arr[i] = 12'(c);
      end
   endtask

   task automatic set_target(input int t);
      set_const(0, 0);
      s_arr[ROWS-1] = 12'(t);
   endtask

   task automatic set_rand();
      for (int i = 0; i < ROWS; i++) begin
         s_arr[i] = 12'($urandom_range(0, 4095));
         c_arr[i] = 12'($urandom_range(0, 4095));
      end
   endtask

   // Entered and left just after a rising edge. mode: 0 continuous, 1 toggling, 2 random bubbles.
   task automatic feed(input int n, input int mode);
      int i   = 0;
      int cyc = 0;
      bit v   = 1'b1;
      bit hs;
      while (i < n && cyc < 200) begin
         case (mode)
            0:       in_valid = 1'b1;
            1:       begin in_valid = v; v = !v; end
            default: in_valid = ($urandom_range(0, 3) != 0);
         endcase
         sum_vec   = s_arr[i];
         carry_vec = c_arr[i];
         @(negedge clk);
         hs = in_valid && in_ready;
         check("ov_and_ir_exclusive", {31'd0, out_valid & in_ready}, 32'd0);
         @(posedge clk);
         #1;
         if (hs) i++;
         cyc++;
      end
      in_valid = 1'b0;
      if (cyc >= 200) check("feed_timeout", 32'd0, 32'd1);
   endtask

   // Must be called right after the last-row handshake edge: out_valid is due one cycle later.
   task automatic consume(input int bp);
      int e;
      int b;
      int bi;
      e = block_sad();
      @(negedge clk);
      check("out_valid_latency", {31'd0, out_valid}, 32'd1);
      check("sad", {16'd0, sad}, e);
      check("cand_idx", {28'd0, cand_idx}, cur_cand);
      check("in_ready_in_out", {31'd0, in_ready}, 32'd0);
      for (int k = 0; k < bp; k++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check("bp_sad_stable", {16'd0, sad}, e);
         check("bp_cand_stable", {28'd0, cand_idx}, cur_cand);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      sads.push_back(e);
      cur_cand++;
      model_best(b, bi);
      @(negedge clk);
      check("best_sad", {16'd0, best_sad}, b);
      check("best_idx", {28'd0, best_idx}, bi);
      check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
      if (cur_cand == NC) begin
         check("search_done", {31'd0, search_done}, 32'd1);
         check("in_ready_done", {31'd0, in_ready}, 32'd0);
      end else begin
         check("in_ready_next", {31'd0, in_ready}, 32'd1);
         check("cand_next", {28'd0, cand_idx}, cur_cand);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input bit with_row);
      in_valid  = with_row;
      sum_vec   = 12'($urandom_range(1, 4095));
      carry_vec = 12'($urandom_range(1, 4095));
      start     = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b0;
      sads.delete();
      cur_cand = 0;
      @(negedge clk);
      check("start_in_ready", {31'd0, in_ready}, 32'd1);
      check("start_out_valid", {31'd0, out_valid}, 32'd0);
      check("start_cand", {28'd0, cand_idx}, 32'd0);
      check("start_sad", {16'd0, sad}, 32'd0);
      check("start_best_sad", {16'd0, best_sad}, 32'hFFFF);
      check("start_best_idx", {28'd0, best_idx}, 32'd0);
      check("start_done", {31'd0, search_done}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sad"}, {16'd0, sad}, 32'd0);
      check({tag, "_cand"}, {28'd0, cand_idx}, 32'd0);
      check({tag, "_best_sad"}, {16'd0, best_sad}, 32'hFFFF);
      check({tag, "_best_idx"}, {28'd0, best_idx}, 32'd0);
      check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_done"}, {31'd0, search_done}, 32'd0);
   endtask

   initial begin
      int b;
      int bi;
      rst       = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sum_vec   = 12'd0;
      carry_vec = 12'd0;
      cur_cand  = 0;
      #12;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         @(negedge clk);
         check("idle_in_ready", {31'd0, in_ready}, 32'd0);
         check("idle_out_valid", {31'd0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;

      // Basic block with backpressure, then random candidates to the end of the search.
      do_start(1'b1);
      set_const(100, 20);
      feed(ROWS, 0);
      check("basic_sad_960", {16'd0, sad}, 32'd960);
      consume(5);
      for (int c = 1; c < NC; c++) begin
         set_rand();
         feed(ROWS, 2);
         consume($urandom_range(0, 3));
      end
      model_best(b, bi);
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         @(negedge clk);
         check("done_held", {31'd0, search_done}, 32'd1);
         check("done_in_ready", {31'd0, in_ready}, 32'd0);
         check("done_best_sad", {16'd0, best_sad}, b);
         check("done_best_idx", {28'd0, best_idx}, bi);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;

      // Minimum tracking with a tie.
      do_start(1'b0);
      set_target(500); feed(ROWS, 0); consume(0);
      set_target(300); feed(ROWS, 0); consume(1);
      set_target(300); feed(ROWS, 0); consume(0);
      set_target(700); feed(ROWS, 0); consume(2);
      check("min_best_sad_300", {16'd0, best_sad}, 32'd300);
      check("min_best_idx_1", {28'd0, best_idx}, 32'd1);
      check("min_done", {31'd0, search_done}, 32'd1);

      // Bubbles.
      do_start(1'b0);
      set_const(2040, 0);
      feed(ROWS, 1);
      check("bubble_sad_16320", {16'd0, sad}, 32'd16320);
      consume(0);

      // Abort after 3 rows of the second block; start arrives with a row present.
      set_rand();
      feed(3, 0);
      do_start(1'b1);
      check("abort_no_out", {31'd0, out_valid}, 32'd0);
      set_rand();
      feed(ROWS, 2);
      consume(1);

      // Async reset while out_valid is high.
      set_rand();
      feed(ROWS, 0);
      #2;
      check("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         @(negedge clk);
         check_reset_outputs("post_reset");
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;

      do_start(1'b0);
      set_rand();
      feed(ROWS, 2);
      consume(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1);
   end

endmodule
